// File: rtl/sm_regdump.sv
// Debug-port sequencer: walks the core's debug register-read port over
// [FIRST_REG..LAST_REG] and streams {address, value} beats over valid/ready.
module sm_regdump #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31,
  parameter int GAP_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cont,
  input  logic [GAP_W-1:0] gap,
  input  logic             abort,
  output logic [4:0]       regAddr,
  input  logic [31:0]      regData,
  output logic             outValid,
  input  logic             outReady,
  output logic [4:0]       outAddr,
  output logic [31:0]      outData,
  output logic             outLast,
  output logic             busy,
  output logic [15:0]      dumpCount
);

  if (FIRST_REG < 0 || FIRST_REG > LAST_REG || LAST_REG > 31) begin : gBadRange
    $error("sm_regdump: require 0 <= FIRST_REG <= LAST_REG <= 31");
  end

  localparam logic [4:0] FIRST_A = 5'(FIRST_REG);
  localparam logic [4:0] LAST_A  = 5'(LAST_REG);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SEND,
    ST_GAP
  } state_t;

  state_t           state, nextState;
  logic [4:0]       idx, idxNext;
  logic [GAP_W-1:0] gapCnt;
  logic             capture;
  logic             dumpDone;
  logic             loadGap;

  // idx doubles as the registered debug address; it rests at FIRST_REG in IDLE and GAP
  assign regAddr  = idx;
  assign outValid = (state == ST_SEND);
  assign busy     = (state != ST_IDLE);

  always_comb begin
    nextState = state;
    idxNext   = idx;
    capture   = 1'b0;
    dumpDone  = 1'b0;
    loadGap   = 1'b0;
    if (abort) begin
      nextState = ST_IDLE;
      idxNext   = FIRST_A;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            nextState = ST_SETUP;
            idxNext   = FIRST_A;
          end
        end
        ST_SETUP: begin
          nextState = ST_SEND;
          capture   = 1'b1;
        end
        ST_SEND: begin
          if (outReady) begin
            if (idx != LAST_A) begin
              nextState = ST_SETUP;
              idxNext   = idx + 5'd1;
            end else begin
              dumpDone = 1'b1;
              idxNext  = FIRST_A;
              if (cont && (gap != '0)) begin
                nextState = ST_GAP;
                loadGap   = 1'b1;
              end else if (cont) begin
                nextState = ST_SETUP;
              end else begin
                nextState = ST_IDLE;
              end
            end
          end
        end
        ST_GAP: begin
          // leaving on the count of 1 gives exactly 'gap' cycles in this state
          if (gapCnt == GAP_W'(1)) nextState = ST_SETUP;
        end
        default: nextState = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idx       <= FIRST_A;
      gapCnt    <= '0;
      outAddr   <= '0;
      outData   <= '0;
      outLast   <= 1'b0;
      dumpCount <= '0;
    end else begin
      state <= nextState;
      idx   <= idxNext;
      if (capture) begin
        outData <= regData;
        outAddr <= idx;
        outLast <= (idx == LAST_A);
      end
      if (dumpDone) dumpCount <= dumpCount + 16'd1;
      if (loadGap) gapCnt <= gap;
      else if (state == ST_GAP && !abort) gapCnt <= gapCnt - GAP_W'(1);
    end
  end

endmodule

// File: tb/tb_sm_regdump.sv
// Scoreboard bench for sm_regdump: one full-range instance and one
// FIRST_REG=2..LAST_REG=4 instance sharing a modelled core register file.
module tb_sm_regdump;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
    logic        l;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A (defaults)
  logic        rstnA, startA, contA, abortA;
  logic [15:0] gapA;
  logic [4:0]  regAddrA, oaA;
  logic [31:0] regDataA, odA;
  logic        vA, rA, olA, busyA;
  logic [15:0] dcA;
  // DUT B (2..4)
  logic        rstnB, startB, contB, abortB;
  logic [15:0] gapB;
  logic [4:0]  regAddrB, oaB;
  logic [31:0] regDataB, odB;
  logic        vB, rB, olB, busyB;
  logic [15:0] dcB;

  logic rdyReg, rdyRegB, stallAt7;
  // core register file: PC at address 0, rN = N*0x0101, r9 writable
  logic        we;
  logic [31:0] wd;
  bit          r9Written;
  logic [31:0] r9Val;

  always @(posedge clk) if (we) begin
    r9Written <= 1'b1;
    r9Val     <= wd;
  end

  assign regDataA = (regAddrA == 5'd0) ? 32'h40 :
                    (regAddrA == 5'd9 && r9Written) ? r9Val : 32'(regAddrA) * 32'h0101;
  assign regDataB = (regAddrB == 5'd0) ? 32'h40 :
                    (regAddrB == 5'd9 && r9Written) ? r9Val : 32'(regAddrB) * 32'h0101;
  assign rA = stallAt7 ? (oaA != 5'd7) : rdyReg;
  assign rB = rdyRegB;

  sm_regdump dutA (
    .clk(clk), .rst_n(rstnA), .start(startA), .cont(contA), .gap(gapA), .abort(abortA),
    .regAddr(regAddrA), .regData(regDataA), .outValid(vA), .outReady(rA),
    .outAddr(oaA), .outData(odA), .outLast(olA), .busy(busyA), .dumpCount(dcA)
  );

  sm_regdump #(.FIRST_REG(2), .LAST_REG(4), .GAP_W(16)) dutB (
    .clk(clk), .rst_n(rstnB), .start(startB), .cont(contB), .gap(gapB), .abort(abortB),
    .regAddr(regAddrB), .regData(regDataB), .outValid(vB), .outReady(rB),
    .outAddr(oaB), .outData(odB), .outLast(olB), .busy(busyB), .dumpCount(dcB)
  );

  beat_t qA[$];
  beat_t qB[$];
  int    chk = 0, err = 0, mChk = 0, mErr = 0;

  // Monitor: pops on every handshake and checks beats held stable while stalled
  logic  stallA = 1'b0, stallB = 1'b0;
  beat_t holdA, holdB, eA, eB;
  always @(negedge clk) begin
    if (rstnA && vA && rA) begin
      mChk++;
      if (qA.size() == 0) begin
        mErr++;
        $display("FAIL A_beat: got unexpected addr %0d data %h, required no beat", oaA, odA);
      end else begin
        eA = qA.pop_front();
        if ({oaA, odA, olA} !== eA) begin
          mErr++;
          $display("FAIL A_beat: got addr %0d data %h last %b, required addr %0d data %h last %b",
                   oaA, odA, olA, eA.a, eA.d, eA.l);
        end
      end
    end
    if (rstnA && stallA && vA) begin
      mChk++;
      if ({oaA, odA, olA} !== holdA) begin
        mErr++;
        $display("FAIL A_stable: got %h, required %h", {oaA, odA, olA}, holdA);
      end
    end
    stallA <= rstnA && vA && !rA;
    holdA  <= {oaA, odA, olA};

    if (rstnB && vB && rB) begin
      mChk++;
      if (qB.size() == 0) begin
        mErr++;
        $display("FAIL B_beat: got unexpected addr %0d data %h, required no beat", oaB, odB);
      end else begin
        eB = qB.pop_front();
        if ({oaB, odB, olB} !== eB) begin
          mErr++;
          $display("FAIL B_beat: got addr %0d data %h last %b, required addr %0d data %h last %b",
                   oaB, odB, olB, eB.a, eB.d, eB.l);
        end
      end
    end
    if (rstnB && stallB && vB) begin
      mChk++;
      if ({oaB, odB, olB} !== holdB) begin
        mErr++;
        $display("FAIL B_stable: got %h, required %h", {oaB, odB, olB}, holdB);
      end
    end
    stallB <= rstnB && vB && !rB;
    holdB  <= {oaB, odB, olB};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic pushRange(input bit sel, input int first, input int upto, input int lastReg,
                           input logic [31:0] r9v);
    for (int i = first; i <= upto; i++) begin
      beat_t b;
      b.a = 5'(i);
      b.d = (i == 0) ? 32'h40 : ((i == 9) ? r9v : 32'(i) * 32'h0101);
      b.l = (i == lastReg);
      if (sel) qB.push_back(b);
      else qA.push_back(b);
    end
  endtask

  task automatic waitIdle(input bit sel, input int budget, output int n);
    n = 0;
    while ((sel ? busyB : busyA) && n < budget) begin
      tick();
      n++;
    end
    check(sel ? "B_idle_timeout" : "A_idle_timeout", {31'd0, sel ? busyB : busyA}, 32'd0);
  endtask

  task automatic pulseStart(input bit sel);
    if (sel) startB = 1'b1;
    else startA = 1'b1;
    tick();
    startA = 1'b0;
    startB = 1'b0;
  endtask

  // Continuous run on B: four dumps, cont dropped after the third; checks the period
  task automatic contRun(input logic [15:0] g, input int period, input logic [15:0] dcEnd);
    int times[4];
    int k, n, dummy;
    logic [15:0] prev;
    contB = 1'b1;
    gapB  = g;
    for (int d = 0; d < 4; d++) pushRange(1, 2, 4, 4, 32'h0909);
    pulseStart(1);
    prev = dcB;
    k = 0;
    n = 0;
    while (k < 4 && n < 500) begin
      tick();
      n++;
      if (dcB != prev) begin
        times[k] = n;
        k++;
        prev = dcB;
        if (k == 3) contB = 1'b0;
      end
    end
    check("B_cont_dumps_seen", k, 4);
    if (k == 4) begin
      for (int j = 1; j < 4; j++) check("B_cont_period", times[j] - times[j-1], period);
    end
    waitIdle(1, 100, dummy);
    check("B_cont_dumpCount", {16'd0, dcB}, {16'd0, dcEnd});
    check("B_cont_queue_empty", qB.size(), 0);
  endtask

  initial begin
    int n;
    bit wrote;
    rstnA = 0; rstnB = 0;
    startA = 0; startB = 0; contA = 0; contB = 0; abortA = 0; abortB = 0;
    gapA = '0; gapB = '0; rdyReg = 1; rdyRegB = 1; stallAt7 = 0; we = 0; wd = '0;
    #12;
    check("A_rst_regAddr", regAddrA, 0);
    check("A_rst_outValid", vA, 0);
    check("A_rst_outAddr", oaA, 0);
    check("A_rst_outData", odA, 0);
    check("A_rst_outLast", olA, 0);
    check("A_rst_busy", busyA, 0);
    check("A_rst_dumpCount", dcA, 0);
    check("B_rst_regAddr", regAddrB, 2);
    rstnA = 1; rstnB = 1;
    tick();
    tick();
    check("A_idle_after_reset", busyA, 0);

    // single full dump, consumer always ready
    pushRange(0, 0, 31, 31, 32'h0909);
    pulseStart(0);
    check("A_busy_cycle1", busyA, 1);
    check("A_valid_cycle1", vA, 0);
    tick();
    check("A_valid_cycle2", vA, 1);
    check("A_first_data_pc", odA, 32'h40);
    waitIdle(0, 200, n);
    check("A_busy_low_cycle", 2 + n, 65);
    check("A_dumpCount_1", dcA, 1);
    check("A_queue_empty_1", qA.size(), 0);

    // backpressure: ready high about 30% of cycles
    pushRange(0, 0, 31, 31, 32'h0909);
    pulseStart(0);
    n = 0;
    while (busyA && n < 3000) begin
      rdyReg = ($urandom_range(0, 99) < 30);
      tick();
      n++;
    end
    rdyReg = 1;
    check("A_bp_finished", busyA, 0);
    check("A_dumpCount_2", dcA, 2);
    check("A_queue_empty_bp", qA.size(), 0);

    // abort while address 7 is stalled in SEND
    stallAt7 = 1;
    pushRange(0, 0, 6, 31, 32'h0909);
    pulseStart(0);
    n = 0;
    while (!(vA && oaA == 5'd7) && n < 100) begin
      tick();
      n++;
    end
    tick();
    tick();
    check("A_stalled_valid", vA, 1);
    check("A_stalled_addr", oaA, 7);
    abortA = 1;
    tick();
    abortA = 0;
    check("A_abort_valid", vA, 0);
    check("A_abort_busy", busyA, 0);
    check("A_abort_dumpCount", dcA, 2);
    check("A_abort_regAddr", regAddrA, 0);
    check("A_abort_queue", qA.size(), 0);
    stallAt7 = 0;
    pushRange(0, 0, 31, 31, 32'h0909);
    pulseStart(0);
    waitIdle(0, 200, n);
    check("A_dumpCount_3", dcA, 3);
    check("A_queue_empty_3", qA.size(), 0);

    // core writes r9 in the cycle of its SETUP: old value now, new value next dump
    pushRange(0, 0, 31, 31, 32'h0909);
    pulseStart(0);
    wrote = 0;
    n = 0;
    while (busyA && n < 200) begin
      if (regAddrA == 5'd9 && busyA && !vA && !wrote) begin
        we = 1;
        wd = 32'hDEADBEEF;
        wrote = 1;
      end
      tick();
      we = 0;
      n++;
    end
    check("A_r9_written", wrote, 1);
    pushRange(0, 0, 31, 31, 32'hDEADBEEF);
    pulseStart(0);
    waitIdle(0, 200, n);
    check("A_dumpCount_5", dcA, 5);
    check("A_queue_empty_5", qA.size(), 0);

    // continuous mode on the 2..4 instance
    contRun(16'd3, 9, 16'd4);
    contRun(16'd0, 6, 16'd8);

    // asynchronous reset in the middle of GAP
    contB = 1;
    gapB = 16'd20;
    pushRange(1, 2, 4, 4, 32'h0909);
    pulseStart(1);
    n = 0;
    while (dcB == 16'd8 && n < 100) begin
      tick();
      n++;
    end
    tick();
    tick();
    #2;
    rstnB = 0;
    #1;
    check("B_arst_regAddr", regAddrB, 2);
    check("B_arst_outValid", vB, 0);
    check("B_arst_outAddr", oaB, 0);
    check("B_arst_outData", odB, 0);
    check("B_arst_outLast", olB, 0);
    check("B_arst_busy", busyB, 0);
    check("B_arst_dumpCount", dcB, 0);
    check("B_arst_queue", qB.size(), 0);
    contB = 0;
    #2;
    rstnB = 1;
    for (int i = 0; i < 5; i++) tick();
    check("B_idle_after_arst", busyB, 0);
    check("B_novalid_after_arst", vB, 0);
    pushRange(1, 2, 4, 4, 32'h0909);
    pulseStart(1);
    waitIdle(1, 100, n);
    check("B_dumpCount_after_arst", dcB, 1);
    check("B_queue_empty_end", qB.size(), 0);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", chk + mChk, err + mErr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sm_regdump.md
# sm_regdump

Debug-port sequencer for the schoolMIPS core. It drives the core's debug register-read port (`regAddr` / `regData`) through a configurable register range and streams each `{address, value}` pair to a consumer over a valid/ready handshake. A consumer can be a UART formatter, a display driver or a testbench monitor. It can run one dump per request or dump continuously with a programmable gap, so the whole register file can be observed without the consumer sequencing the port itself.

## Interface
Parameters:
- `FIRST_REG`, default 0: first debug address dumped. Address 0 returns the PC on the core's debug port.
- `LAST_REG`, default 31: last debug address dumped. Must satisfy `FIRST_REG <= LAST_REG <= 31`; violation is a elaboration error.
- `GAP_W`, default 16: width of the inter-dump gap counter.

Ports:
- `clk` in 1: clock. The block has one clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: request a dump. Level-sampled; acted on only in IDLE.
- `cont` in 1: continuous mode. Sampled at the end of each dump.
- `gap` in GAP_W: idle cycles between continuous dumps. Sampled on entry to GAP.
- `abort` in 1: stop immediately and return to IDLE.
- `regAddr` out 5: registered address to the core debug port.
- `regData` in 32: core debug port read data, combinational from `regAddr`.
- `outValid` out 1: beat valid.
- `outReady` in 1: consumer ready.
- `outAddr` out 5: address of the current beat.
- `outData` out 32: value captured for the current beat.
- `outLast` out 1: current beat is `LAST_REG`.
- `busy` out 1: high in every state except IDLE.
- `dumpCount` out 16: number of completed dumps. Wraps at 2^16.

## Operation
- States:
  - IDLE: `regAddr=FIRST_REG`, `outValid=0`.
  - SETUP: `regAddr=idx`; `regData` is settled within this cycle.
  - SEND: `outValid=1`; holds until a handshake occurs.
  - GAP: counts down the gap.
- IDLE -> SETUP when `start=1`. `idx` is loaded with `FIRST_REG`.
- SETUP -> SEND always, after exactly one cycle.
  - At the end of SETUP the block registers `outData<=regData`, `outAddr<=idx` and `outLast<=(idx==LAST_REG)`.
- SEND handshake (`outValid & outReady`):
  - If `idx!=LAST_REG`: `idx<=idx+1`, `regAddr<=idx+1`, next state SETUP.
  - If `idx==LAST_REG`: `dumpCount` increments. Then:
    - `cont=1` and `gap!=0`: go to GAP; counter loaded with `gap`.
    - `cont=1` and `gap==0`: go to SETUP with `idx=FIRST_REG`.
    - Otherwise: go to IDLE.
- GAP: the counter decrements every cycle. When it reaches 1 and is about to decrement, the next state is SETUP with `idx=FIRST_REG`. The total is exactly `gap` cycles in GAP.
- `outData`, `outAddr` and `outLast` are stable for the whole time `outValid` is high. `outValid` never drops without a handshake, except on `abort` or reset.
- `abort` has priority over every other event.
  - Next state is IDLE; `outValid` drops the next cycle; `dumpCount` is not incremented.
  - A handshake in the abort cycle is valid for the consumer but does not complete the dump.
- `start` while busy is ignored; it does not queue.
- Clearing `cont` during a dump ends operation after the current dump. Setting it mid-dump takes effect at that dump's end.
- Snapshot semantics:
  - Each register is sampled at its own SETUP cycle; a dump is not atomic.
  - A register written by the core in the same cycle as its SETUP returns the pre-write value, because the register file writes on the clock edge.
- Reset values: state IDLE, `regAddr=FIRST_REG`, `outValid=0`, `outAddr=0`, `outData=0`, `outLast=0`, `busy=0`, `dumpCount=0`, gap counter 0.

## Timing
- `start` sampled high at edge 0 -> SETUP in cycle 1 -> `outValid` high in cycle 2.
- With `outReady` held at 1, each beat takes 2 cycles (SETUP + SEND). A full 32-register dump occupies 64 cycles from the first SETUP to the last handshake.
- Continuous mode period is `2*(LAST_REG-FIRST_REG+1) + gap` cycles.
- `busy` is registered. It rises in the cycle after `start` is accepted and falls in the cycle after the final handshake or `abort`.
- Reset is asynchronous: outputs take their reset values immediately on `rst_n` falling, mid-dump or otherwise. After `rst_n` rises, the first action is `start` sampled on a clock edge.
- `regAddr` changes only on clock edges; the combinational path `regAddr -> regData -> outData` must close in one cycle.

## Test plan
- Single dump with defaults, `outReady=1`, register file preloaded `rN=N*16'h0101`, PC=0x40: 32 beats, addr 0 carries 0x40, addr 5 carries 0x0505, `outLast` only on addr 31, `dumpCount`=1, `busy` low 65 cycles after start.
- Backpressure: `outReady` toggled with a random 30% duty: every beat is held stable while stalled, no beat is lost or duplicated, addresses arrive strictly ascending.
- Continuous mode with `FIRST_REG=2`, `LAST_REG=4`, `gap=3`: beats 2,3,4 repeat with a 9-cycle period; `dumpCount` increments once per period. Repeat with `gap=0`: period is 6.
- `abort` asserted while SEND holds addr 7 (stalled): `outValid` is 0 the next cycle, state is IDLE, `dumpCount` unchanged. A following `start` begins again at address 0.
- `rst_n` pulled low asynchronously mid-GAP: all outputs are at reset values before the next edge, `dumpCount=0`, and the block stays idle until `start`.
- Core writes r9 in the same cycle as its SETUP: the beat for addr 9 carries the old value; the next dump carries the new value.
